// File: rtl/dlx_fetch_unit.sv
// ---------------------------------------------------------------------------
// dlx_fetch_unit
//
// Instruction-fetch front end of the DLX pipeline. It drives the address of a
// synchronous instruction ROM, collects the returned words into a small
// circular instruction queue (each word tagged with its PC), and presents the
// queue head to decode as a valid/ready stream. A taken branch/jump from
// execute flushes the queue and the in-flight fetch and restarts fetching at
// the target.
//
// Ports:
//   clock          rising-edge clock
//   reset          asynchronous, active-high reset
//   pc_o           ROM address (ROM samples it each edge, data next cycle)
//   inst_in        ROM read data for the address sampled at the previous edge
//   redirect_i     taken branch/jump this cycle
//   redirect_pc_i  redirect target (bits [1:0] are dropped)
//   id_ready_i     decode accepts the head entry this cycle
//   if_valid_o     queue head is valid
//   if_inst_o      head instruction (NOP_WORD when empty)
//   if_pc_o        head instruction address (0 when empty)
//   if_npc_o       if_pc_o + 4
//   misalign_o     one-cycle pulse: redirect target was not word aligned
// ---------------------------------------------------------------------------
module dlx_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  output logic [31:0] pc_o,
  input  logic [31:0] inst_in,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        id_ready_i,
  output logic        if_valid_o,
  output logic [31:0] if_inst_o,
  output logic [31:0] if_pc_o,
  output logic [31:0] if_npc_o,
  output logic        misalign_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;  // pointer width
  localparam int CW = $clog2(DEPTH + 1);                // count width
  localparam int OW = CW + 1;                           // occupancy width

  // Queue storage
  logic [31:0] inst_mem [DEPTH];
  logic [31:0] pc_mem   [DEPTH];

  // Control state
  logic [31:0]   pc_q;
  logic [31:0]   issued_pc_q;
  logic          inflight_q;
  logic [PW-1:0] head_q;
  logic [PW-1:0] tail_q;
  logic [CW-1:0] count_q;
  logic          misalign_q;

  // Per-cycle decisions
  logic          pop;
  logic          push;
  logic          issue;
  logic [OW-1:0] occupancy;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Occupancy after this edge's pop, counting the word still in flight from
  // the ROM. Issuing only while it is below DEPTH guarantees every returned
  // word has a free slot, so the queue can never overflow.
  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    pop       = 1'b0;
    push      = 1'b0;
    issue     = 1'b0;
    occupancy = '0;
    if (!redirect_i) begin
      pop       = if_valid_o & id_ready_i;
      push      = inflight_q;
      occupancy = OW'(count_q) + OW'(inflight_q) - OW'(pop);
      issue     = (occupancy <= OW'(DEPTH - 1));
    end
  end

  // Fetch PC, in-flight tracking and queue pointers.
  // NOTE: sequential state is written only with non-blocking assignments so
  // every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc_q        <= RESET_PC;
      issued_pc_q <= '0;
      inflight_q  <= 1'b0;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      misalign_q  <= 1'b0;
    end else begin
      misalign_q <= redirect_i & (|redirect_pc_i[1:0]);
      if (redirect_i) begin
        // Flush: drop queued entries and the word the ROM returns next cycle.
        pc_q       <= {redirect_pc_i[31:2], 2'b00};
        inflight_q <= 1'b0;
        head_q     <= '0;
        tail_q     <= '0;
        count_q    <= '0;
      end else begin
        inflight_q <= issue;
        if (issue) begin
          issued_pc_q <= pc_q;
          pc_q        <= pc_q + 32'd4;
        end
        if (push) tail_q <= ptr_inc(tail_q);
        if (pop)  head_q <= ptr_inc(head_q);
        case ({push, pop})
          2'b10:   count_q <= count_q + CW'(1);
          2'b01:   count_q <= count_q - CW'(1);
          default: count_q <= count_q;
        endcase
      end
    end
  end

  // NOTE: queue storage carries no reset; count_q alone decides which slots
  // are meaningful, and the outputs mask the head while the queue is empty.
  always_ff @(posedge clock) begin
    if (push) begin
      inst_mem[tail_q] <= inst_in;
      pc_mem[tail_q]   <= issued_pc_q;
    end
  end

  assign pc_o       = pc_q;
  assign misalign_o = misalign_q;
  assign if_valid_o = (count_q != '0);
  assign if_inst_o  = if_valid_o ? inst_mem[head_q] : NOP_WORD;
  assign if_pc_o    = if_valid_o ? pc_mem[head_q] : 32'h0000_0000;
  assign if_npc_o   = if_pc_o + 32'd4;

endmodule

// File: tb/tb_dlx_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_dlx_fetch_unit
//
// Directed bench for dlx_fetch_unit. A synchronous ROM model returns
// 32'h1000_0000 + (addr >> 2) one cycle after sampling pc_o. Inputs change
// and outputs are sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_dlx_fetch_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] pc_o;
  logic [31:0] inst_in = 32'h0;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        id_ready_i;
  logic        if_valid_o;
  logic [31:0] if_inst_o;
  logic [31:0] if_pc_o;
  logic [31:0] if_npc_o;
  logic        misalign_o;

  int tests_run    = 0;
  int tests_failed = 0;

  dlx_fetch_unit dut (
    .clock         (clock),
    .reset         (reset),
    .pc_o          (pc_o),
    .inst_in       (inst_in),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .id_ready_i    (id_ready_i),
    .if_valid_o    (if_valid_o),
    .if_inst_o     (if_inst_o),
    .if_pc_o       (if_pc_o),
    .if_npc_o      (if_npc_o),
    .misalign_o    (misalign_o)
  );

  always #5 clock = ~clock;

  // Synchronous instruction ROM: word at 4i is 32'h1000_0000 + i.
  always @(posedge clock) inst_in <= 32'h1000_0000 + (pc_o >> 2);

  task automatic check(input string tag, input logic [31:0] actual,
                       input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  task automatic check_head(input string tag, input logic [31:0] pc,
                            input logic [31:0] inst);
    check({tag, " valid"}, 32'(if_valid_o), 32'd1);
    check({tag, " pc"},    if_pc_o,         pc);
    check({tag, " inst"},  if_inst_o,       inst);
    check({tag, " npc"},   if_npc_o,        pc + 32'd4);
  endtask

  initial begin
    reset         = 1'b1;
    redirect_i    = 1'b0;
    redirect_pc_i = 32'h0;
    id_ready_i    = 1'b1;

    // Cold start
    repeat (3) @(negedge clock);
    check("rst pc_o",     pc_o,               32'h0);
    check("rst valid",    32'(if_valid_o),    32'd0);
    check("rst inst",     if_inst_o,          32'h0);
    check("rst if_pc",    if_pc_o,            32'h0);
    check("rst npc",      if_npc_o,           32'h4);
    check("rst misalign", 32'(misalign_o),    32'd0);
    reset = 1'b0;
    @(negedge clock);
    check("cold e1 valid", 32'(if_valid_o), 32'd0);
    check("cold e1 pc_o",  pc_o,            32'h4);
    @(negedge clock);
    check_head("cold e2", 32'h0, 32'h1000_0000);
    check("cold e2 pc_o", pc_o, 32'h8);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clock);
      check_head("stream", 32'(4 * k), 32'h1000_0000 + 32'(k));
      check("stream pc_o", pc_o, 32'(4 * k + 8));
    end

    // Stall: head 0x14 held, queue fills with 0x18, pc_o freezes at 0x1C
    id_ready_i = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      check_head("stall", 32'h14, 32'h1000_0005);
      check("stall pc_o", pc_o, 32'h1C);
    end
    id_ready_i = 1'b1;
    for (int k = 6; k <= 9; k++) begin
      @(negedge clock);
      check_head("resume", 32'(4 * k), 32'h1000_0000 + 32'(k));
    end

    // Asynchronous reset 2 ns after an edge
    @(posedge clock);
    #2 reset = 1'b1;
    #1;
    check("arst valid", 32'(if_valid_o), 32'd0);
    check("arst pc_o",  pc_o,            32'h0);
    check("arst inst",  if_inst_o,       32'h0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("restart e1 valid", 32'(if_valid_o), 32'd0);
    @(negedge clock);
    check_head("restart", 32'h0, 32'h1000_0000);
    @(negedge clock);
    check_head("restart", 32'h4, 32'h1000_0001);
    @(negedge clock);
    check_head("restart", 32'h8, 32'h1000_0002);

    // Fill the queue (0x8, 0xC), then redirect to 0x40
    id_ready_i = 1'b0;
    @(negedge clock);
    check_head("full", 32'h8, 32'h1000_0002);
    check("full pc_o", pc_o, 32'h10);
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h40;
    @(negedge clock);
    redirect_i = 1'b0;
    id_ready_i = 1'b1;
    check("redir e1 valid",    32'(if_valid_o), 32'd0);
    check("redir e1 pc_o",     pc_o,            32'h40);
    check("redir e1 misalign", 32'(misalign_o), 32'd0);
    @(negedge clock);
    check("redir e2 valid", 32'(if_valid_o), 32'd0);
    check("redir e2 pc_o",  pc_o,            32'h44);
    @(negedge clock);
    check_head("redir tgt", 32'h40, 32'h1000_0010);
    @(negedge clock);
    check_head("redir seq", 32'h44, 32'h1000_0011);
    @(negedge clock);
    check_head("redir seq", 32'h48, 32'h1000_0012);

    // Misaligned redirect coincident with ready
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h43;
    @(negedge clock);
    redirect_i = 1'b0;
    check("mis e1 misalign", 32'(misalign_o), 32'd1);
    check("mis e1 pc_o",     pc_o,            32'h40);
    check("mis e1 valid",    32'(if_valid_o), 32'd0);
    @(negedge clock);
    check("mis e2 misalign", 32'(misalign_o), 32'd0);
    check("mis e2 valid",    32'(if_valid_o), 32'd0);
    @(negedge clock);
    check_head("mis tgt", 32'h40, 32'h1000_0010);
    check("mis e3 misalign", 32'(misalign_o), 32'd0);

    // Back-to-back redirects: the last one wins
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h100;
    @(negedge clock);
    check("b2b e1 pc_o", pc_o, 32'h100);
    redirect_pc_i = 32'h200;
    @(negedge clock);
    redirect_i = 1'b0;
    check("b2b e2 pc_o",  pc_o,            32'h200);
    check("b2b e2 valid", 32'(if_valid_o), 32'd0);
    @(negedge clock);
    check("b2b e3 valid", 32'(if_valid_o), 32'd0);
    @(negedge clock);
    check_head("b2b tgt", 32'h200, 32'h1000_0080);

    // Address wrap at the top of memory
    redirect_i    = 1'b1;
    redirect_pc_i = 32'hFFFF_FFFC;
    @(negedge clock);
    redirect_i = 1'b0;
    check("wrap e1 pc_o", pc_o, 32'hFFFF_FFFC);
    @(negedge clock);
    check("wrap e2 pc_o",  pc_o,            32'h0);
    check("wrap e2 valid", 32'(if_valid_o), 32'd0);
    @(negedge clock);
    check_head("wrap top", 32'hFFFF_FFFC, 32'h4FFF_FFFF);
    check("wrap top npc", if_npc_o, 32'h0);
    check("wrap e3 pc_o", pc_o, 32'h4);
    @(negedge clock);
    check_head("wrap zero", 32'h0, 32'h1000_0000);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/dlx_fetch_unit.md
Name: dlx_fetch_unit

Overview:
- Instruction-fetch front end of the DLX pipeline. Sits between the synchronous instruction ROM and the decode stage.
- Drives the ROM address and captures returned words into a small instruction queue with their PCs.
- Presents a valid/ready stream to decode, and services branch/jump redirects by flushing queued and in-flight fetches.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- DEPTH, 2, instruction queue entries; legal range 2..8.
- NOP_WORD, 32'h0000_0000, value driven on if_inst_o when the queue is empty.

Ports:
- clock  input  1  single clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- pc_o  output  32  ROM address; the ROM samples it on each rising edge and returns the word in the following cycle.
- inst_in  input  32  ROM read data for the address sampled at the previous edge.
- redirect_i  input  1  branch_en | jump_en from execute; taken redirect this cycle.
- redirect_pc_i  input  32  redirect target address.
- id_ready_i  input  1  decode accepts the head entry this cycle.
- if_valid_o  output  1  queue head is valid.
- if_inst_o  output  32  head instruction.
- if_pc_o  output  32  head instruction address.
- if_npc_o  output  32  if_pc_o + 4, modulo 2^32.
- misalign_o  output  1  one-cycle pulse: redirect target had non-zero bits [1:0].

Behaviour:
- Reset (async, asserted at any time, overrides everything):
  - pc_o=RESET_PC; queue count=0; inflight_q=0.
  - if_valid_o=0, if_inst_o=NOP_WORD, if_pc_o=0, if_npc_o=4, misalign_o=0.
- Definitions:
  - pop = if_valid_o & id_ready_i & ~redirect_i.
  - issue = ~redirect_i & (count_q + inflight_q - pop <= DEPTH-1).
- On issue at edge E:
  - ROM samples old pc_o.
  - inflight_q<=1 and issued_pc_q<=old pc_o.
  - pc_o<=pc_o+4 (32-bit wrap, no flag).
- If no issue: pc_o holds and inflight_q<=0. ROM re-reads the same address; nothing is pushed.
- Push: at any edge where inflight_q=1 and no redirect, write {inst_in, issued_pc_q} at the queue tail.
- Push and pop at the same edge are both applied; count is unchanged.
- Queue behaviour:
  - Circular buffer with head and tail pointers.
  - count never exceeds DEPTH (guaranteed by the issue rule).
  - Pop on empty is impossible because if_valid_o=0.
- Outputs: if_valid_o=(count_q!=0). if_inst_o and if_pc_o come from the head entry, or NOP_WORD/0 when empty.
- Throughput: with id_ready_i held 1, one instruction per cycle in steady state (count=1, inflight=1).
- Redirect at edge E (priority over pop, push and issue):
  - Queue cleared; inflight_q<=0, so the word returned in the next cycle is discarded.
  - pc_o<=redirect_pc_i with bits [1:0] forced to 0.
  - misalign_o<=|redirect_pc_i[1:0] for one cycle; it is 0 at all other edges.
- Redirect latency: the target is issued at E+1, pushed at E+2, and if_valid_o=1 after E+2. No stale instruction is ever presented after E.
- Back-to-back redirects: the last one wins; each restarts the latency.
- Stall: id_ready_i=0 leaves head outputs stable. pc_o freezes once count+inflight=DEPTH.
- No internal FSM beyond RUN. The post-reset cold start is the same as a redirect to RESET_PC: first valid after the second edge following reset release.

Test Plan:
- ROM word at 4i = 32'h1000_0000+i; reset 3 cycles, then release with id_ready_i=1 -> pc_o=0 during reset; if_valid_o=1 after the 2nd edge; if_pc_o sequence 0,4,8,... one per cycle; if_inst_o=1000_0000,1000_0001,...; if_npc_o=if_pc_o+4.
- Steady stream, then id_ready_i=0 for 5 cycles -> count reaches 2 and pc_o freezes; head holds the same pc/inst. On id_ready_i=1 the sequence resumes with no duplicate or missing PC.
- Queue full (pcs 0x8, 0xC), redirect_i=1 with target 0x40 -> next cycle if_valid_o=0 and pc_o=0x40; if_valid_o=1 with if_pc_o=0x40, inst 1000_0010 two edges after the redirect; 0x8, 0xC and 0x10 never reappear.
- Redirect to 0x43 coincident with id_ready_i=1 -> the head is not counted as consumed; pc_o=0x40; misalign_o is 1 for exactly one cycle; first output pc is 0x40.
- reset asserted 2 ns after an edge mid-stream -> if_valid_o=0, pc_o=RESET_PC, if_inst_o=NOP_WORD immediately, before the next edge; restart behaves like the first scenario.
- Redirect to 0xFFFF_FFFC, ready held -> if_pc_o shows 0xFFFF_FFFC with if_npc_o=0, then if_pc_o=0 next cycle; pc_o wraps to 0 without error.
